// File: rtl/rx_axis_crc_filter_fifo.sv
// Store-and-forward RX filter: a frame reaches m_axis only after a good CRC verdict.
// Define RX_FILTER_STATS_EN to build the good/drop frame counters; otherwise they read 0.
module rx_axis_crc_filter_fifo #(
   parameter int unsigned P_ADDR_W       = 9,
   parameter int unsigned P_META_DEPTH_W = 4,
   parameter int unsigned P_CRC_TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [63:0] s_axis_rdata,
   input  logic [79:0] s_axis_ruser,
   input  logic [7:0]  s_axis_rkeep,
   input  logic        s_axis_rlast,
   input  logic        s_axis_rvalid,
   input  logic        i_crc_valid,
   input  logic        i_crc_error,
   output logic [63:0] m_axis_tdata,
   output logic [79:0] m_axis_tuser,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] o_good_cnt,
   output logic [31:0] o_drop_cnt
);
   localparam int unsigned TMO_W = $clog2(P_CRC_TIMEOUT + 1);
   localparam logic [P_ADDR_W:0]       BUF_DEPTH  = {1'b1, {P_ADDR_W{1'b0}}};
   localparam logic [P_META_DEPTH_W:0] META_DEPTH = {1'b1, {P_META_DEPTH_W{1'b0}}};
   localparam logic [TMO_W-1:0]        TMO_MAX    = TMO_W'(P_CRC_TIMEOUT);

   typedef enum logic [1:0] {StIdle, StRecv, StWait, StDrop} state_e;
   typedef logic [P_ADDR_W:0] ptr_t;

   state_e state_q, state_d;
   ptr_t wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d, start_q, start_d, wp;
   logic [79:0] ruser_q, ruser_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic dlast_q, dlast_d, drop_pre_q, drop_pre_d;
   logic [P_META_DEPTH_W:0] meta_wr_q, meta_wr_d, meta_rd_q, meta_rd_d, meta_cnt;

   logic [72:0] mem [2**P_ADDR_W];
   logic [79:0] meta_mem [2**P_META_DEPTH_W];
   logic [P_ADDR_W-1:0] waddr;
   logic we, push, good_inc, first, meta_full_eff, timeout;
   logic [1:0] drop_inc;

   logic [72:0] mem_rd_q, out_q, out_d;
   logic ram_v_q, ram_v_d, tvalid_q, tvalid_d, issue, move, pop;

   assign meta_cnt = meta_wr_q - meta_rd_q;
   assign timeout  = (tmo_q == TMO_MAX);

   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      cmt_ptr_d     = cmt_ptr_q;
      start_d       = start_q;
      ruser_d       = ruser_q;
      tmo_d         = tmo_q;
      dlast_d       = dlast_q;
      drop_pre_d    = drop_pre_q;
      we            = 1'b0;
      waddr         = wr_ptr_q[P_ADDR_W-1:0];
      push          = 1'b0;
      good_inc      = 1'b0;
      drop_inc      = 2'd0;
      first         = 1'b0;
      wp            = wr_ptr_q;
      meta_full_eff = 1'b0;
      unique case (state_q)
         StIdle: first = s_axis_rvalid;
         StRecv: begin
            if (s_axis_rvalid) begin
               if ((wr_ptr_q - rd_ptr_q) == BUF_DEPTH) begin
                  state_d    = StDrop;
                  wr_ptr_d   = start_q;
                  dlast_d    = s_axis_rlast;
                  tmo_d      = '0;
                  drop_pre_d = 1'b0;
               end else begin
                  we       = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (s_axis_rlast) begin
                     state_d = StWait;
                     tmo_d   = '0;
                  end
               end
            end
         end
         StWait: begin
            tmo_d = tmo_q + 1'b1;
            if (i_crc_valid && !i_crc_error) begin
               cmt_ptr_d = wr_ptr_q;
               push      = 1'b1;
               good_inc  = 1'b1;
               state_d   = StIdle;
               first     = s_axis_rvalid;
            end else if (i_crc_valid || timeout) begin
               wr_ptr_d = start_q;
               wp       = start_q;
               drop_inc = 2'd1;
               state_d  = StIdle;
               first    = s_axis_rvalid;
            end else if (s_axis_rvalid) begin
               // Verdict never came: drop the pending frame and the one now arriving.
               wr_ptr_d   = start_q;
               drop_inc   = 2'd2;
               drop_pre_d = 1'b1;
               state_d    = StDrop;
               dlast_d    = s_axis_rlast;
               tmo_d      = '0;
            end
         end
         StDrop: begin
            if (!dlast_q) begin
               if (s_axis_rvalid && s_axis_rlast) begin
                  dlast_d = 1'b1;
                  tmo_d   = '0;
               end
            end else begin
               tmo_d = tmo_q + 1'b1;
               if (i_crc_valid || timeout) begin
                  drop_inc = drop_pre_q ? 2'd0 : 2'd1;
                  state_d  = StIdle;
                  first    = s_axis_rvalid;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      meta_full_eff = (meta_cnt == META_DEPTH) || (push && (meta_cnt == META_DEPTH - 1'b1));
      if (first) begin
         start_d    = wp;
         ruser_d    = s_axis_ruser;
         tmo_d      = '0;
         drop_pre_d = 1'b0;
         if (meta_full_eff || ((wp - rd_ptr_q) == BUF_DEPTH)) begin
            state_d = StDrop;
            dlast_d = s_axis_rlast;
         end else begin
            we       = 1'b1;
            waddr    = wp[P_ADDR_W-1:0];
            wr_ptr_d = wp + 1'b1;
            state_d  = s_axis_rlast ? StWait : StRecv;
         end
      end
   end

   // mem_rd_q doubles as a skid slot so reads can run ahead of a stalled output.
   assign move  = ram_v_q && (!tvalid_q || m_axis_tready);
   assign issue = (cmt_ptr_q != rd_ptr_q) && (!ram_v_q || move);
   assign pop   = tvalid_q && m_axis_tready && out_q[72];

   always_comb begin
      rd_ptr_d  = rd_ptr_q + {{P_ADDR_W{1'b0}}, issue};
      ram_v_d   = issue || (ram_v_q && !move);
      tvalid_d  = move || (tvalid_q && !m_axis_tready);
      out_d     = move ? mem_rd_q : out_q;
      meta_wr_d = meta_wr_q + {{P_META_DEPTH_W{1'b0}}, push};
      meta_rd_d = meta_rd_q + {{P_META_DEPTH_W{1'b0}}, pop};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         cmt_ptr_q  <= '0;
         rd_ptr_q   <= '0;
         start_q    <= '0;
         ruser_q    <= '0;
         tmo_q      <= '0;
         dlast_q    <= 1'b0;
         drop_pre_q <= 1'b0;
         meta_wr_q  <= '0;
         meta_rd_q  <= '0;
         ram_v_q    <= 1'b0;
         tvalid_q   <= 1'b0;
         out_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         cmt_ptr_q  <= cmt_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         start_q    <= start_d;
         ruser_q    <= ruser_d;
         tmo_q      <= tmo_d;
         dlast_q    <= dlast_d;
         drop_pre_q <= drop_pre_d;
         meta_wr_q  <= meta_wr_d;
         meta_rd_q  <= meta_rd_d;
         ram_v_q    <= ram_v_d;
         tvalid_q   <= tvalid_d;
         out_q      <= out_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (we) mem[waddr] <= {s_axis_rlast, s_axis_rkeep, s_axis_rdata};
      if (issue) mem_rd_q <= mem[rd_ptr_q[P_ADDR_W-1:0]];
      if (push) meta_mem[meta_wr_q[P_META_DEPTH_W-1:0]] <= ruser_q;
   end

   assign m_axis_tdata  = out_q[63:0];
   assign m_axis_tkeep  = out_q[71:64];
   assign m_axis_tlast  = out_q[72];
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tuser  = tvalid_q ? meta_mem[meta_rd_q[P_META_DEPTH_W-1:0]] : '0;

`ifdef RX_FILTER_STATS_EN
   logic [31:0] good_cnt_q, good_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [32:0] drop_sum;

   always_comb begin
      good_cnt_d = good_cnt_q;
      if (good_inc && (good_cnt_q != 32'hFFFF_FFFF)) good_cnt_d = good_cnt_q + 32'd1;
      drop_sum   = {1'b0, drop_cnt_q} + {31'd0, drop_inc};
      drop_cnt_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         good_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         good_cnt_q <= good_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_good_cnt = good_cnt_q;
   assign o_drop_cnt = drop_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = ^{good_inc, drop_inc};
   assign o_good_cnt   = 32'd0;
   assign o_drop_cnt   = 32'd0;
`endif

endmodule
